// File: rtl/hex_display_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_scanner_if
// Description : Value/load and scan-output bundle for hex_display_scanner.
// Revision    : 1.0 - initial release
// ============================================================================
interface hex_display_scanner_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic                load_ack;
    logic [3:0]          position;
    logic [DIGITS-1:0]   digit_sel;
    logic                blank;
    logic                frame_done;

    modport master (
        output value, load,
        input  load_ack, position, digit_sel, blank, frame_done
    );

    modport slave (
        input  value, load,
        output load_ack, position, digit_sel, blank, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_scanner
// Description : Time-multiplexed hex 7-seg digit scanner with frame-aligned
//               value updates. Define LEADING_ZERO_BLANK_EN to blank leading
//               zero digits.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_display_scanner #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  wire logic               clk,
    input  wire logic               rst,
    hex_display_scanner_if.slave    bus
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_disp;
    logic [4*DIGITS-1:0] r_pend;
    logic                r_pend_valid;
    logic                r_load_ack;
    logic                r_frame_done;

    logic                w_slot_end;
    logic                w_wrap;
    logic [DIGITS-1:0]   w_onehot;

    assign w_slot_end = (r_cnt == c_cnt_last);
    assign w_wrap     = w_slot_end && (r_idx == c_idx_last);
    assign w_onehot   = DIGITS'(1) << r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_disp       <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_load_ack   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_load_ack   <= 1'b0;
            r_frame_done <= 1'b0;

            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Display updates only on the wrap edge; a same-edge load beats the pending one.
            if (w_wrap) begin
                r_frame_done <= 1'b1;
                r_pend_valid <= 1'b0;
                if (bus.load) begin
                    r_disp     <= bus.value;
                    r_load_ack <= 1'b1;
                end else if (r_pend_valid) begin
                    r_disp     <= r_pend;
                    r_load_ack <= 1'b1;
                end
            end else if (bus.load) begin
                r_pend       <= bus.value;
                r_pend_valid <= 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic w_upper_zero;
    // Selected nibble plus everything above it is zero.
    assign w_upper_zero = ((r_disp >> {r_idx, 2'b00}) == '0);

    always_comb begin
        bus.blank     = 1'b0;
        bus.digit_sel = w_onehot;
        if (w_upper_zero && (r_idx != '0)) begin
            bus.blank     = 1'b1;
            bus.digit_sel = '0;
        end
    end
`else
    always_comb begin
        bus.blank     = 1'b0;
        bus.digit_sel = w_onehot;
    end
`endif

    assign bus.position   = r_disp[{r_idx, 2'b00} +: 4];
    assign bus.load_ack   = r_load_ack;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire
